reverse_diffusion: RTL and testbench

AES inverse MixColumns (reverse diffusion) stage of the decryption datapath. It takes a 4x4 byte state and multiplies each column by the fixed inverse matrix over GF(2^8). The result is registered. It sits between the inverse ShiftRows/SubBytes stages and the round-key addition in the decrypt round.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/reverse_diffusion_if.sv | 25 ++
 rtl/inv_mix_column.sv | 41 ++++
 rtl/reverse_diffusion.sv | 52 +++++
 tb/tb_reverse_diffusion.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and MixColumns coefficient constants.
// FORWARD_MODE_EN (optional) makes the forward coefficients MIX_C0..C3 live in the datapath.
package aes_pkg;

  typedef logic [7:0]           byte_t;
  typedef byte_t [3:0]          column_t;
  // First index is the row ([3] = AES row 0), second index is the column.
  typedef byte_t [3:0][3:0]     state_t;

  localparam byte_t INV_MIX_C0 = 8'h0e;
  localparam byte_t INV_MIX_C1 = 8'h0b;
  localparam byte_t INV_MIX_C2 = 8'h0d;
  localparam byte_t INV_MIX_C3 = 8'h09;

  localparam byte_t MIX_C0 = 8'h02;
  localparam byte_t MIX_C1 = 8'h03;
  localparam byte_t MIX_C2 = 8'h01;
  localparam byte_t MIX_C3 = 8'h01;

  function automatic byte_t gf_xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only coefficients below 0x10 are supported, which covers both the
  // forward and inverse MixColumns matrices.
  function automatic byte_t gf_mul(input byte_t b, input byte_t coeff);
    byte_t x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return (coeff[0] ? b  : 8'h00) ^
           (coeff[1] ? x2 : 8'h00) ^
           (coeff[2] ? x4 : 8'h00) ^
           (coeff[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/reverse_diffusion_if.sv
// Streaming state bus between the inverse ShiftRows/SubBytes stages and the round-key add.
// FORWARD_MODE_EN adds the encrypt select sampled alongside in_valid.
interface reverse_diffusion_if;

  logic            in_valid;
  aes_pkg::state_t diffusion_in;
  logic            out_valid;
  aes_pkg::state_t diffusion_out;
`ifdef FORWARD_MODE_EN
  logic            encrypt;
`endif

`ifdef FORWARD_MODE_EN
  modport master (output in_valid, diffusion_in, encrypt,
                  input  out_valid, diffusion_out);
  modport slave  (input  in_valid, diffusion_in, encrypt,
                  output out_valid, diffusion_out);
`else
  modport master (output in_valid, diffusion_in,
                  input  out_valid, diffusion_out);
  modport slave  (input  in_valid, diffusion_in,
                  output out_valid, diffusion_out);
`endif

endinterface

// File: rtl/inv_mix_column.sv
// Combinational (inverse) MixColumns on one 4-byte column; col_i[3] is AES row 0.
// FORWARD_MODE_EN adds encrypt_i to select the forward 02 03 01 01 circulant.
module inv_mix_column
  import aes_pkg::*;
(
  input  column_t col_i,
`ifdef FORWARD_MODE_EN
  input  logic    encrypt_i,
`endif
  output column_t col_o
);

  byte_t coeff [4];

  always_comb begin
    coeff[0] = INV_MIX_C0;
    coeff[1] = INV_MIX_C1;
    coeff[2] = INV_MIX_C2;
    coeff[3] = INV_MIX_C3;
`ifdef FORWARD_MODE_EN
    if (encrypt_i) begin
      coeff[0] = MIX_C0;
      coeff[1] = MIX_C1;
      coeff[2] = MIX_C2;
      coeff[3] = MIX_C3;
    end
`endif
  end

  // Circulant: output row r takes coefficient (k - r) mod 4 for input row k.
  always_comb begin
    // NOTE: assign a default before the loops so every bit is written on every path; otherwise a latch is inferred.
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_o[2'(3 - r)] ^= gf_mul(col_i[2'(3 - k)], coeff[2'(k - r)]);
      end
    end
  end

endmodule

// File: rtl/reverse_diffusion.sv
// AES inverse MixColumns stage: four column mixers feeding one output register stage.
// FORWARD_MODE_EN enables the encrypt select for forward MixColumns at the same latency.
module reverse_diffusion
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  reverse_diffusion_if.slave   bus
);

  state_t mixed;
  state_t diffusion_out_q, diffusion_out_d;
  logic   out_valid_q, out_valid_d;

  for (genvar j = 0; j < 4; j++) begin : g_col
    column_t col_in, col_out;

    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_in[r]   = bus.diffusion_in[r][j];
      assign mixed[r][j] = col_out[r];
    end

    inv_mix_column u_mix (
      .col_i     (col_in),
`ifdef FORWARD_MODE_EN
      .encrypt_i (bus.encrypt),
`endif
      .col_o     (col_out)
    );
  end

  // The data register only loads on in_valid, so idle-cycle garbage never lands in it.
  always_comb begin
    diffusion_out_d = bus.in_valid ? mixed : diffusion_out_q;
    out_valid_d     = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      diffusion_out_q <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      diffusion_out_q <= diffusion_out_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign bus.diffusion_out = diffusion_out_q;
  assign bus.out_valid     = out_valid_q;

endmodule

// File: tb/tb_reverse_diffusion.sv
// Directed bench for reverse_diffusion: FIPS vectors, fixed points, hold/valid, reset priority.
// FORWARD_MODE_EN also exercises the forward transform and a forward/inverse round trip.
module tb_reverse_diffusion;
  import aes_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reverse_diffusion_if bus ();

  reverse_diffusion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: shift-and-add multiply reduced by 0x11b.
  function automatic byte_t m_mul(input byte_t a, input byte_t b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic state_t m_mix(input state_t s, input logic fwd);
    state_t o;
    byte_t  m [4][4];
    if (fwd) m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                   '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    else     m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                   '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 4; r++) begin
        o[3-r][j] = m_mul(m[r][0], s[3][j]) ^ m_mul(m[r][1], s[2][j]) ^
                    m_mul(m[r][2], s[1][j]) ^ m_mul(m[r][3], s[0][j]);
      end
    end
    return o;
  endfunction

  // Present one input at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive(input state_t s, input logic v, input logic enc);
    @(negedge clk);
    bus.in_valid     = v;
    bus.diffusion_in = s;
`ifdef FORWARD_MODE_EN
    bus.encrypt      = enc;
`endif
    @(posedge clk);
    #1;
  endtask

  state_t fips_in, fips_exp, fixed_st, full_st, full_exp, alt_st, rnd_st, fwd_st;
  logic   enc_unused;

  initial begin
    checks = 0;
    errors = 0;
    enc_unused = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.diffusion_in = '0;
`ifdef FORWARD_MODE_EN
    bus.encrypt = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_data",  bus.diffusion_out, '0);
    check("reset_valid", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 inverse MixColumns column, replicated into all four columns.
    fips_in[3]  = {4{8'h8e}};  fips_in[2]  = {4{8'h4d}};
    fips_in[1]  = {4{8'ha1}};  fips_in[0]  = {4{8'hbc}};
    fips_exp[3] = {4{8'hdb}};  fips_exp[2] = {4{8'h13}};
    fips_exp[1] = {4{8'h53}};  fips_exp[0] = {4{8'h45}};
    drive(fips_in, 1'b1, enc_unused);
    check("fips_data",  bus.diffusion_out, fips_exp);
    check("fips_valid", 128'(bus.out_valid), 128'(1'b1));

    // Fixed points: each row holds columns {01, c6, 00, 01}.
    for (int r = 0; r < 4; r++) fixed_st[r] = {8'h01, 8'hc6, 8'h00, 8'h01};
    drive(fixed_st, 1'b1, enc_unused);
    check("fixed_data",  bus.diffusion_out, fixed_st);
    check("fixed_valid", 128'(bus.out_valid), 128'(1'b1));

    full_st[3] = {8'h7b, 8'h05, 8'h42, 8'h4a};
    full_st[2] = {8'h1e, 8'hd0, 8'h20, 8'h40};
    full_st[1] = {8'h94, 8'h83, 8'h18, 8'h52};
    full_st[0] = {8'h94, 8'hc4, 8'h43, 8'hfb};
    full_exp   = m_mix(full_st, 1'b0);
    drive(full_st, 1'b1, enc_unused);
    check("full_b33", 128'(bus.diffusion_out[3][3]), 128'(8'h40));
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("full_r%0d_c%0d", r, j), 128'(bus.diffusion_out[r][j]), 128'(full_exp[r][j]));
      end
    end

    // Back-to-back: a second state on the very next cycle.
    for (int r = 0; r < 4; r++) alt_st[r] = {8'h00, 8'hff, 8'h80, 8'h1b} ^ {4{8'(r * 17)}};
    drive(alt_st, 1'b1, enc_unused);
    check("b2b_data",  bus.diffusion_out, m_mix(alt_st, 1'b0));
    check("b2b_valid", 128'(bus.out_valid), 128'(1'b1));

    // Hold: one FIPS pulse, then idle with changing input.
    drive(fips_in, 1'b1, enc_unused);
    check("pulse_data", bus.diffusion_out, fips_exp);
    drive(full_st, 1'b0, enc_unused);
    check("hold1_data",  bus.diffusion_out, fips_exp);
    check("hold1_valid", 128'(bus.out_valid), 128'(1'b0));
    drive('1, 1'b0, enc_unused);
    check("hold2_data",  bus.diffusion_out, fips_exp);
    check("hold2_valid", 128'(bus.out_valid), 128'(1'b0));

    // Reset wins over a simultaneous valid input.
    drive(full_st, 1'b1, enc_unused);
    check("pre_reset_valid", 128'(bus.out_valid), 128'(1'b1));
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.diffusion_in = fips_in;
    @(posedge clk);
    #1;
    check("rst_pri_data",  bus.diffusion_out, '0);
    check("rst_pri_valid", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;

`ifdef FORWARD_MODE_EN
    drive(fips_exp, 1'b1, 1'b1);
    check("fwd_fips", bus.diffusion_out, fips_in);
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) rnd_st[r][j] = 8'($urandom);
    drive(rnd_st, 1'b1, 1'b1);
    fwd_st = bus.diffusion_out;
    check("fwd_rand", fwd_st, m_mix(rnd_st, 1'b1));
    drive(fwd_st, 1'b1, 1'b0);
    check("round_trip", bus.diffusion_out, rnd_st);
`else
    rnd_st = '0;
    fwd_st = '0;
`endif

    drive('0, 1'b0, enc_unused);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
